// File: rtl/ct_lsu_st_data_align_pkg.sv
// Shared types and constants for the store-data lane aligner.
// Covers size encoding, FSM state, beat payload and the byte-count mask helper.
package ct_lsu_st_data_align_pkg;

  localparam int unsigned PA_W       = 40;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned SRC_W      = 64;
  localparam int unsigned BANK_W     = LINE_BYTES * 8;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned LINE_W     = PA_W - OFF_W;
  localparam int unsigned BE_W       = LINE_BYTES;
  localparam int unsigned MASK_W     = 2 * LINE_BYTES;

  localparam logic [1:0] ST_BYTE  = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_WORD  = 2'd2;
  localparam logic [1:0] ST_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2
  } st_state_e;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [BANK_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              split;
    logic              last;
  } wb_beat_t;

  // Contiguous byte mask for a store of the given size, anchored at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      ST_BYTE:  m = 8'h01;
      ST_HALF:  m = 8'h03;
      ST_WORD:  m = 8'h0F;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ct_lsu_st_rot.sv
// Combinational store rotator: lane-rotated data, 32-bit two-line byte mask
// and line-crossing flag. Shared with the atomic store path.
module ct_lsu_st_rot
  import ct_lsu_st_data_align_pkg::*;
(
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic [SRC_W-1:0]  data,
  output logic [SRC_W-1:0]  rot_c,
  output logic [MASK_W-1:0] mask_c,
  output logic              split_c
);

  logic [5:0] sh;

  always_comb begin
    sh      = {off[2:0], 3'b000};
    // A zero shift makes the right-shift term fall off entirely, giving data back.
    rot_c   = (data << sh) | (data >> (7'd64 - 7'(sh)));
    mask_c  = MASK_W'(size_byte_mask(size)) << off;
    split_c = |mask_c[MASK_W-1:LINE_BYTES];
  end

endmodule

// File: rtl/ct_lsu_st_data_align.sv
// Store-data aligner: rotates a 64-bit store into 128-bit bank lanes, builds
// byte enables and splits line-crossing stores into two beats.
module ct_lsu_st_data_align
  import ct_lsu_st_data_align_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               rtu_yy_xx_flush,
  input  logic               st_vld,
  output logic               st_rdy,
  input  logic [PA_W-1:0]    st_addr,
  input  logic [1:0]         st_size,
  input  logic [SRC_W-1:0]   st_data,
  output logic               wb_vld,
  input  logic               wb_rdy,
  output logic [LINE_W-1:0]  wb_line_addr,
  output logic [BANK_W-1:0]  wb_data,
  output logic [BE_W-1:0]    wb_be,
  output logic               wb_split,
  output logic               wb_last
);

  st_state_e         state_q, state_d;
  wb_beat_t          beat_q, beat_d;
  logic [BE_W-1:0]   be_hi_q, be_hi_d;
  logic              vld_q, vld_d;
  logic              accept;

  logic [SRC_W-1:0]  rot_c;
  logic [MASK_W-1:0] mask_c;
  logic              split_c;

  ct_lsu_st_rot u_rot (
    .off     (st_addr[OFF_W-1:0]),
    .size    (st_size),
    .data    (st_data),
    .rot_c   (rot_c),
    .mask_c  (mask_c),
    .split_c (split_c)
  );

  // State and beat registers.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      beat_q  <= '0;
      be_hi_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      be_hi_q <= be_hi_d;
      vld_q   <= vld_d;
    end
  end

  // Handshake, next state and next beat contents.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    be_hi_d = be_hi_q;
    st_rdy  = (state_q == IDLE)
            | ((state_q == B0) & wb_rdy & ~beat_q.split)
            | ((state_q == B1) & wb_rdy);
    accept  = st_vld & st_rdy & ~rtu_yy_xx_flush;

    if (rtu_yy_xx_flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d      = B0;
      beat_d.line  = st_addr[PA_W-1:OFF_W];
      beat_d.data  = {rot_c, rot_c};
      beat_d.be    = mask_c[BE_W-1:0];
      beat_d.split = split_c;
      beat_d.last  = ~split_c;
      be_hi_d      = mask_c[MASK_W-1:BE_W];
    end else begin
      unique case (state_q)
        B0: begin
          if (wb_rdy) begin
            if (beat_q.split) begin
              state_d     = B1;
              beat_d.be   = be_hi_q;
              beat_d.line = beat_q.line + LINE_W'(1);
              beat_d.last = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        B1: begin
          if (wb_rdy) state_d = IDLE;
        end
        default: ;
      endcase
    end

    vld_d = (state_d != IDLE);
  end

  assign wb_vld       = vld_q;
  assign wb_line_addr = beat_q.line;
  assign wb_data      = beat_q.data;
  assign wb_be        = beat_q.be;
  assign wb_split     = beat_q.split;
  assign wb_last      = beat_q.last;

endmodule

// File: tb/tb_ct_lsu_st_data_align.sv
// Scoreboard bench for ct_lsu_st_data_align: byte-level reference model,
// directed scenarios and randomized stores with backpressure and flush.
module tb_ct_lsu_st_data_align;

  typedef struct {
    logic [35:0]  line;
    logic [127:0] data;
    logic [15:0]  be;
    logic         split;
    logic         last;
  } exp_beat_t;

  logic         clk;
  logic         cpurst_b;
  logic         flush;
  logic         st_vld;
  logic         st_rdy;
  logic [39:0]  st_addr;
  logic [1:0]   st_size;
  logic [63:0]  st_data;
  logic         wb_vld;
  logic         wb_rdy;
  logic [35:0]  wb_line_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;
  logic         wb_split;
  logic         wb_last;

  int checks   = 0;
  int failures = 0;
  exp_beat_t exp_q[$];
  logic prev_acc_split = 1'b0;

  ct_lsu_st_data_align dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (cpurst_b),
    .rtu_yy_xx_flush (flush),
    .st_vld          (st_vld),
    .st_rdy          (st_rdy),
    .st_addr         (st_addr),
    .st_size         (st_size),
    .st_data         (st_data),
    .wb_vld          (wb_vld),
    .wb_rdy          (wb_rdy),
    .wb_line_addr    (wb_line_addr),
    .wb_data         (wb_data),
    .wb_be           (wb_be),
    .wb_split        (wb_split),
    .wb_last         (wb_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic split_of(input logic [39:0] addr, input logic [1:0] size);
    return (int'(addr[3:0]) + (1 << size)) > 16;
  endfunction

  // Reference: place each store byte at its absolute lane, split by line.
  function automatic void model_push(input logic [39:0] addr, input logic [1:0] size,
                                     input logic [63:0] data);
    exp_beat_t b0, b1;
    int off, n;
    off = int'(addr[3:0]);
    n   = 1 << size;
    b0.be = '0;
    b1.be = '0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = off + i;
      if (p < 16) b0.be[p] = 1'b1;
      else        b1.be[p - 16] = 1'b1;
    end
    for (int l = 0; l < 16; l++) begin
      int k;
      k = (l + 16 - off) % 8;
      b0.data[l*8 +: 8] = data[k*8 +: 8];
    end
    b0.line  = addr[39:4];
    b0.split = (b1.be != 16'h0);
    b0.last  = !b0.split;
    b1.data  = b0.data;
    b1.line  = b0.line + 36'd1;
    b1.split = b0.split;
    b1.last  = 1'b1;
    exp_q.push_back(b0);
    if (b0.split) exp_q.push_back(b1);
  endfunction

  // One clock of stimulus; reports whether the DUT accepted the store.
  task automatic step(input logic vld, input logic [39:0] addr, input logic [1:0] size,
                      input logic [63:0] data, input logic rdy, input logic fl,
                      input logic rstn, output logic acc);
    @(posedge clk);
    #1;
    st_vld   = vld;
    st_addr  = addr;
    st_size  = size;
    st_data  = data;
    wb_rdy   = rdy;
    flush    = fl;
    cpurst_b = rstn;
    #1;
    if (prev_acc_split) chk("st_rdy_b0_split", 128'(st_rdy), 128'(1'b0));
    acc = vld && st_rdy && !fl && rstn;
    if (acc) model_push(addr, size, data);
    prev_acc_split = acc && split_of(addr, size);
  endtask

  task automatic idle(input logic rdy);
    logic a;
    step(1'b0, '0, 2'd0, '0, rdy, 1'b0, 1'b1, a);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_vld"},   128'(wb_vld),       128'(1'b0));
    chk({tag, "_data"},  wb_data,            128'h0);
    chk({tag, "_be"},    128'(wb_be),        128'(16'h0));
    chk({tag, "_line"},  128'(wb_line_addr), 128'(36'h0));
    chk({tag, "_split"}, 128'(wb_split),     128'(1'b0));
    chk({tag, "_last"},  128'(wb_last),      128'(1'b0));
  endtask

  // Monitor: compares delivered beats, output stability under stall, flush/reset drop.
  logic         prev_drop  = 1'b0;
  logic         prev_stall = 1'b0;
  logic [35:0]  p_line;
  logic [127:0] p_data;
  logic [15:0]  p_be;
  logic         p_split, p_last;

  always @(negedge clk) begin
    if (prev_drop) chk("vld_after_drop", 128'(wb_vld), 128'(1'b0));
    if (prev_stall) begin
      chk("hold_line",  128'(wb_line_addr), 128'(p_line));
      chk("hold_data",  wb_data,            p_data);
      chk("hold_be",    128'(wb_be),        128'(p_be));
      chk("hold_flags", 128'({wb_split, wb_last}), 128'({p_split, p_last}));
    end
    if (cpurst_b && wb_vld && wb_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(wb_be), 128'(16'h0));
      end else begin
        exp_beat_t e;
        e = exp_q.pop_front();
        chk("beat_line",  128'(wb_line_addr), 128'(e.line));
        chk("beat_data",  wb_data,            e.data);
        chk("beat_be",    128'(wb_be),        128'(e.be));
        chk("beat_flags", 128'({wb_split, wb_last}), 128'({e.split, e.last}));
      end
    end
    if (flush || !cpurst_b) exp_q.delete();
    prev_drop  = flush || !cpurst_b;
    prev_stall = wb_vld && !wb_rdy && !flush && cpurst_b;
    p_line  = wb_line_addr;
    p_data  = wb_data;
    p_be    = wb_be;
    p_split = wb_split;
    p_last  = wb_last;
  end

  initial begin
    logic acc;
    logic [39:0] a;
    logic [1:0]  sz;
    logic [63:0] d;
    logic        rdy;
    logic        fl;
    int          tries;

    cpurst_b = 1'b0; flush = 1'b0; st_vld = 1'b0; wb_rdy = 1'b0;
    st_addr = '0; st_size = '0; st_data = '0;

    step(1'b0, '0, 2'd0, '0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 2'd0, '0, 1'b0, 1'b0, 1'b0, acc);
    idle(1'b0);
    reset_chk("rst");
    chk("st_rdy_idle", 128'(st_rdy), 128'(1'b1));

    // Aligned dword
    step(1'b1, 40'h1000, 2'd3, 64'h0807060504030201, 1'b1, 1'b0, 1'b1, acc);
    chk("t1_acc", 128'(acc), 128'(1'b1));
    idle(1'b1);
    chk("t1_vld",  128'(wb_vld), 128'(1'b1));
    chk("t1_be",   128'(wb_be), 128'(16'h00FF));
    chk("t1_data", 128'(wb_data[63:0]), 128'(64'h0807060504030201));
    chk("t1_line", 128'(wb_line_addr), 128'(36'h100));
    chk("t1_last", 128'(wb_last), 128'(1'b1));
    idle(1'b1);
    chk("t1_done", 128'(wb_vld), 128'(1'b0));

    // Offset byte
    step(1'b1, 40'h100D, 2'd0, 64'hAB, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1);
    chk("t2_be",   128'(wb_be), 128'(16'h2000));
    chk("t2_lane", 128'(wb_data[111:104]), 128'(8'hAB));
    idle(1'b1);

    // Split word
    step(1'b1, 40'h100E, 2'd2, 64'hDDCCBBAA, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1);
    chk("t3_be0",   128'(wb_be), 128'(16'hC000));
    chk("t3_lanes0", 128'(wb_data[127:112]), 128'(16'hBBAA));
    chk("t3_line0", 128'(wb_line_addr), 128'(36'h100));
    idle(1'b1);
    chk("t3_be1",   128'(wb_be), 128'(16'h0003));
    chk("t3_lanes1", 128'(wb_data[15:0]), 128'(16'hDDCC));
    chk("t3_line1", 128'(wb_line_addr), 128'(36'h101));
    chk("t3_last1", 128'(wb_last), 128'(1'b1));
    idle(1'b1);

    // Backpressure on a split dword
    step(1'b1, 40'h1009, 2'd3, 64'h1122334455667788, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("t4_be0", 128'(wb_be), 128'(16'hFE00));
    idle(1'b1);
    idle(1'b1);
    chk("t4_be1", 128'(wb_be), 128'(16'h0001));
    idle(1'b1);

    // Line-address wrap with a back-to-back store
    step(1'b1, 40'hFF_FFFF_FFFC, 2'd3, 64'hCAFEF00DDEADBEEF, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 40'h2004, 2'd2, 64'h0000000012345678, 1'b1, 1'b0, 1'b1, acc);
    chk("t5_b0_line", 128'(wb_line_addr), 128'(36'hF_FFFF_FFFF));
    step(1'b1, 40'h2004, 2'd2, 64'h0000000012345678, 1'b1, 1'b0, 1'b1, acc);
    chk("t5_wrap_line", 128'(wb_line_addr), 128'(36'h0));
    chk("t5_b2b_acc", 128'(acc), 128'(1'b1));
    idle(1'b1);
    chk("t5_no_bubble", 128'(wb_vld), 128'(1'b1));
    chk("t5_be", 128'(wb_be), 128'(16'h00F0));
    idle(1'b1);

    // Flush with beat 1 pending
    step(1'b1, 40'h100E, 2'd2, 64'hDDCCBBAA, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1);
    step(1'b0, '0, 2'd0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk("t6_in_b1", 128'(wb_be), 128'(16'h0003));
    idle(1'b1);
    chk("t6_vld", 128'(wb_vld), 128'(1'b0));
    chk("t6_idle_rdy", 128'(st_rdy), 128'(1'b1));

    // Reset while in B0
    step(1'b1, 40'h100E, 2'd2, 64'hDDCCBBAA, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 2'd0, '0, 1'b0, 1'b0, 1'b0, acc);
    idle(1'b0);
    reset_chk("t7");

    // Randomized stores with backpressure and occasional flush
    for (int n = 0; n < 300; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(1'($urandom_range(0, 1)));
      a  = {8'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1) a[3:0] = 4'(8 + $urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      d  = {$urandom, $urandom};
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 64) begin
        rdy = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 24) == 0);
        step(1'b1, a, sz, d, rdy, fl, 1'b1, acc);
        tries++;
      end
      if (!acc) chk("accept_timeout", 128'(tries), 128'(0));
    end

    tries = 0;
    while (exp_q.size() != 0 && tries < 100) begin
      idle(1'b1);
      tries++;
    end
    idle(1'b1);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_vld", 128'(wb_vld), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
